in_collector_n: RTL and testbench
=================================

IN_COLLECTOR_N -- requirements
Module: in_collector_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and input-bus width in bits (>=1).
REQ-002 The block SHALL have parameter NUM_OPS, default 2, meaning operands collected per operation (>=2).
REQ-003 The block SHALL define CNTW = max(1, clog2(NUM_OPS)) as the operand-index width.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-006 The block SHALL have port inReady  input  1  producer flag: inBus holds a valid operand.
REQ-007 The block SHALL have port inBus  input  WIDTH  operand data.
REQ-008 The block SHALL have port coreBusy  input  1  downstream core cannot accept a start.
REQ-009 The block SHALL have port clear  input  1  synchronous abort of the current collection.
REQ-010 The block SHALL have port operands  output  NUM_OPS*WIDTH  collected operands; operand k at bits [k*WIDTH +: WIDTH].
REQ-011 The block SHALL have port inAccepted  output  1  handshake acknowledge to the producer.
REQ-012 The block SHALL have port startFP  output  1  single-cycle start pulse to the core.
REQ-013 The block SHALL have port opIndex  output  CNTW  index of the operand currently expected.

Function
REQ-014 The controller SHALL be a Moore FSM with states IDLE, LOAD, ACCEPT, WAIT_CORE, START; all outputs SHALL be decoded from the registered state, index and registers only.
REQ-015 IDLE: inAccepted=0; inReady=1 -> LOAD, else stay.
REQ-016 LOAD: exactly one cycle; inBus SHALL be written into operand slot opIndex at the exiting edge; -> ACCEPT.
REQ-017 ACCEPT: inAccepted=1; stay while inReady=1; on inReady=0: if opIndex<NUM_OPS-1 then opIndex+1 and -> IDLE; else opIndex=0 and -> START if coreBusy=0, else -> WAIT_CORE.
REQ-018 WAIT_CORE: inAccepted=0, inReady ignored; coreBusy=0 -> START.
REQ-019 START: startFP=1 for exactly one cycle; -> IDLE.
REQ-020 Latency: inReady sampled high at edge E0 -> slot written and inAccepted=1 after edge E1.
REQ-021 Last operand with coreBusy=0: inReady sampled low at edge E -> startFP high for the cycle after E only.
REQ-022 Each operand slot SHALL hold its value until rewritten; all WIDTH bits stored, no truncation.
REQ-023 inBus changes outside LOAD SHALL NOT affect operands.
REQ-024 clear=1 at an edge SHALL force IDLE and opIndex=0 from any state, override all other transitions, suppress a pending startFP, and leave operand slots unchanged.
REQ-025 opIndex SHALL never exceed NUM_OPS-1; it wraps to 0 only via REQ-017 or REQ-024.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, opIndex=0, all operand slots 0, inAccepted=0, startFP=0, regardless of clk.
REQ-027 Reset asserted mid-handshake SHALL discard the partial set; after release the block SHALL expect operand 0.
REQ-028 After rst rises, the first transition SHALL occur no earlier than the next rising clk edge.

Verification (WIDTH=32, NUM_OPS=3)
REQ-029 Reset: rst=0 mid-LOAD -> operands=0, inAccepted=0, startFP=0, opIndex=0 without a clock edge.
REQ-030 Full set: feed 0x11111111, 0x22222222, 0x80000001, each inReady held until inAccepted=1 then dropped, coreBusy=0 -> opIndex steps 0,1,2,0; operands={0x80000001,0x22222222,0x11111111}; exactly one startFP pulse one cycle after final inReady fall.
REQ-031 Back-pressure: coreBusy=1 during third handshake, released 5 cycles later -> FSM in WAIT_CORE, inAccepted=0, no startFP until the cycle after coreBusy sampled 0, then one pulse.
REQ-032 Long hold: inReady held high 10 cycles on operand 0 -> inAccepted high 9 cycles, slot 0 written once (later inBus changes ignored), opIndex stays 0 until inReady falls.
REQ-033 Abort: clear=1 after two operands accepted -> opIndex=0, no startFP, slots 0/1 retain values; next full set overwrites and starts normally.
REQ-034 Back-to-back: second set presented immediately after startFP -> second operand 0 accepted with REQ-020 latency, second startFP emitted, no lost or duplicated pulses.

Source files
------------

// File: rtl/in_collector_n.sv
// Operand collector: gathers NUM_OPS words from a producer over a
// req/ack handshake and fires a one-cycle start pulse to the core
// once the full set is held. Moore controller, outputs from state only.
module in_collector_n #(
   parameter  int WIDTH   = 32,
   parameter  int NUM_OPS = 2,
   localparam int CNTW    = ($clog2(NUM_OPS) > 1) ? $clog2(NUM_OPS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inReady,
   input  logic [WIDTH-1:0]         inBus,
   input  logic                     coreBusy,
   input  logic                     clear,
   output logic [NUM_OPS*WIDTH-1:0] operands,
   output logic                     inAccepted,
   output logic                     startFP,
   output logic [CNTW-1:0]          opIndex
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ACCEPT,
      S_WAIT_CORE,
      S_START
   } state_t;

   localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NUM_OPS - 1);

   state_t                        r_state;
   state_t                        w_state_nxt;
   logic [CNTW-1:0]               r_idx;
   logic [CNTW-1:0]               w_idx_nxt;
   logic                          w_load;
   logic [NUM_OPS-1:0][WIDTH-1:0] r_ops;

   // State and operand-index registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Operand slots: written only on the edge leaving LOAD.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ops <= '0;
      end else if (w_load) begin
         r_ops[r_idx] <= inBus;
      end
   end

   // Next-state, next-index and slot-write decode; clear overrides all,
   // including the LOAD write, so an aborted load leaves slots intact.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      if (clear) begin
         w_state_nxt = S_IDLE;
         w_idx_nxt   = '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (inReady) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
               w_load      = 1'b1;
               w_state_nxt = S_ACCEPT;
            end
            S_ACCEPT: begin
               if (!inReady) begin
                  if (r_idx < LAST_IDX) begin
                     w_idx_nxt   = r_idx + CNTW'(1);
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_idx_nxt   = '0;
                     w_state_nxt = coreBusy ? S_WAIT_CORE : S_START;
                  end
               end
            end
            S_WAIT_CORE: begin
               if (!coreBusy) w_state_nxt = S_START;
            end
            S_START: begin
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   // Moore output decode from registered state, index and slots.
   always_comb begin
      operands   = r_ops;
      inAccepted = (r_state == S_ACCEPT);
      startFP    = (r_state == S_START);
      opIndex    = r_idx;
   end

endmodule

// File: tb/tb_in_collector_n.sv
// Self-checking bench for in_collector_n (WIDTH=32, NUM_OPS=3): a constant
// vector table, hand-written corner sequences and a randomized phase
// checked against a transaction-level operand/start model.
module tb_in_collector_n;

   localparam int W = 32;
   localparam int N = 3;

   logic           clk      = 1'b0;
   logic           rst      = 1'b0;
   logic           inReady  = 1'b0;
   logic [W-1:0]   inBus    = '0;
   logic           coreBusy = 1'b0;
   logic           clear    = 1'b0;
   logic [N*W-1:0] operands;
   logic           inAccepted;
   logic           startFP;
   logic [1:0]     opIndex;

   int vectors     = 0;
   int miscompares = 0;
   int pulses      = 0;

   // Model: operand slots, expected index, number of start pulses owed.
   logic [W-1:0] m_ops [N];
   int           m_idx;
   int           m_starts;

   typedef struct {
      logic [31:0] data;
      int          hold;
      bit          busy;
      int          wait_cyc;
      logic [1:0]  idx0;
      logic [1:0]  idx1;
      bit          start;
      int          acks;
   } vec_t;

   vec_t tbl [8];

   in_collector_n #(.WIDTH(W), .NUM_OPS(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .inReady    (inReady),
      .inBus      (inBus),
      .coreBusy   (coreBusy),
      .clear      (clear),
      .operands   (operands),
      .inAccepted (inAccepted),
      .startFP    (startFP),
      .opIndex    (opIndex)
   );

   always #5 clk = ~clk;

   // Count start pulses, sampled mid-cycle.
   always @(negedge clk) if (startFP) pulses++;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [95:0] mvec();
      return {m_ops[2], m_ops[1], m_ops[0]};
   endfunction

   // One producer handshake, started from IDLE at a negedge.
   task automatic handshake(input logic [31:0] data, input int hold, input bit busy,
                            input int wait_cyc, input logic [1:0] idx0, input logic [1:0] idx1,
                            input bit exp_start, output int acks);
      acks     = 0;
      inBus    = data;
      inReady  = 1'b1;
      coreBusy = busy;
      tick();
      check("load_ack", inAccepted, 0);
      check("load_idx", opIndex, idx0);
      tick();
      check("ack_rise", inAccepted, 1);
      check("slot_wr", operands[int'(idx0)*W +: W], data);
      acks += int'(inAccepted);
      for (int h = 0; h < hold; h++) begin
         inBus = $urandom;
         tick();
         check("ack_hold", inAccepted, 1);
         check("idx_hold", opIndex, idx0);
         check("slot_hold", operands[int'(idx0)*W +: W], data);
         acks += int'(inAccepted);
      end
      inReady = 1'b0;
      inBus   = $urandom;
      tick();
      check("ack_fall", inAccepted, 0);
      check("idx_next", opIndex, idx1);
      check("start", startFP, exp_start && !busy);
      if (exp_start) begin
         if (busy) begin
            for (int w = 0; w < wait_cyc; w++) begin
               inReady = 1'($urandom_range(0, 1));
               tick();
               check("wait_nostart", startFP, 0);
               check("wait_noack", inAccepted, 0);
            end
            inReady  = 1'b0;
            coreBusy = 1'b0;
            tick();
            check("start_rel", startFP, 1);
         end
         tick();
         check("start_1cyc", startFP, 0);
      end
      coreBusy = 1'b0;
   endtask

   // Handshake whose expectations come from the model.
   task automatic model_hs(input logic [31:0] d, input int hold, input bit busy, input int wc);
      int         acks;
      logic [1:0] i0;
      logic [1:0] i1;
      bit         st;
      i0 = 2'(m_idx);
      st = (m_idx == N - 1);
      i1 = st ? 2'd0 : 2'(m_idx + 1);
      handshake(d, hold, busy, wc, i0, i1, st, acks);
      check("acks", acks, hold + 1);
      m_ops[m_idx] = d;
      m_idx = st ? 0 : m_idx + 1;
      if (st) m_starts++;
      check("ops", operands, mvec());
   endtask

   initial begin : main
      int          acks;
      logic [31:0] d;

      tbl[0] = '{32'h11111111, 0, 1'b0, 0, 2'd0, 2'd1, 1'b0, 1};
      tbl[1] = '{32'h22222222, 0, 1'b0, 0, 2'd1, 2'd2, 1'b0, 1};
      tbl[2] = '{32'h80000001, 0, 1'b0, 0, 2'd2, 2'd0, 1'b1, 1};
      tbl[3] = '{32'hDEADBEEF, 8, 1'b0, 0, 2'd0, 2'd1, 1'b0, 9};
      tbl[4] = '{32'h0000FFFF, 0, 1'b0, 0, 2'd1, 2'd2, 1'b0, 1};
      tbl[5] = '{32'hFFFFFFFF, 0, 1'b1, 5, 2'd2, 2'd0, 1'b1, 1};
      tbl[6] = '{32'h00000001, 2, 1'b0, 0, 2'd0, 2'd1, 1'b0, 3};
      tbl[7] = '{32'h12345678, 0, 1'b1, 3, 2'd1, 2'd2, 1'b0, 1};

      for (int k = 0; k < N; k++) m_ops[k] = '0;
      m_idx    = 0;
      m_starts = 0;

      #23 rst = 1'b1;
      tick();
      check("rst_ops", operands, 0);
      check("rst_ack", inAccepted, 0);
      check("rst_start", startFP, 0);
      check("rst_idx", opIndex, 0);

      // Constant vector table: full set, long hold, back-pressure.
      for (int i = 0; i < 8; i++) begin
         handshake(tbl[i].data, tbl[i].hold, tbl[i].busy, tbl[i].wait_cyc,
                   tbl[i].idx0, tbl[i].idx1, tbl[i].start, acks);
         check("tbl_acks", acks, tbl[i].acks);
         m_ops[m_idx] = tbl[i].data;
         m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
         if (tbl[i].start) m_starts++;
         if (i == 2) check("full_set", operands, 96'h80000001_22222222_11111111);
         if (i == 5) check("second_set", operands, 96'hFFFFFFFF_0000FFFF_DEADBEEF);
      end
      tick();
      check("tbl_pulses", pulses, 2);

      // Abort after two operands of a set.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      m_idx = 0;
      check("clr_idx", opIndex, 0);
      check("clr_ack", inAccepted, 0);
      check("clr_start", startFP, 0);
      check("clr_ops", operands, mvec());
      tick();
      check("clr_pulses", pulses, m_starts);
      for (int k = 0; k < N; k++) model_hs($urandom, 0, 1'b0, 0);

      // Clear landing on the LOAD cycle: slot must not be written.
      inBus   = 32'hCAFEF00D;
      inReady = 1'b1;
      tick();
      clear   = 1'b1;
      inReady = 1'b0;
      tick();
      clear = 1'b0;
      check("clrld_idx", opIndex, 0);
      check("clrld_ops", operands, mvec());
      tick();
      check("clrld_ack", inAccepted, 0);

      // Clear while waiting on the core: pending start is dropped.
      model_hs($urandom, 0, 1'b0, 0);
      model_hs($urandom, 1, 1'b0, 0);
      d        = $urandom;
      inBus    = d;
      inReady  = 1'b1;
      coreBusy = 1'b1;
      tick();
      tick();
      check("clrw_ack", inAccepted, 1);
      inReady = 1'b0;
      tick();
      check("clrw_wait_ack", inAccepted, 0);
      check("clrw_wait_start", startFP, 0);
      clear = 1'b1;
      tick();
      clear    = 1'b0;
      coreBusy = 1'b0;
      m_ops[2] = d;
      m_idx    = 0;
      check("clrw_idx", opIndex, 0);
      check("clrw_start0", startFP, 0);
      tick();
      check("clrw_start1", startFP, 0);
      tick();
      check("clrw_start2", startFP, 0);
      check("clrw_ops", operands, mvec());
      check("clrw_pulses", pulses, m_starts);

      // Asynchronous reset in the middle of LOAD.
      inBus   = $urandom;
      inReady = 1'b1;
      tick();
      #2 rst = 1'b0;
      #1;
      check("arst_ops", operands, 0);
      check("arst_ack", inAccepted, 0);
      check("arst_start", startFP, 0);
      check("arst_idx", opIndex, 0);
      inReady = 1'b0;
      tick();
      #3 rst = 1'b1;
      #1;
      check("rel_ack", inAccepted, 0);
      check("rel_idx", opIndex, 0);
      tick();
      check("rel_idle_ack", inAccepted, 0);
      for (int k = 0; k < N; k++) m_ops[k] = '0;
      m_idx = 0;
      for (int k = 0; k < N; k++) model_hs($urandom, $urandom_range(0, 2), 1'b0, 0);

      // Randomized traffic against the model.
      for (int r = 0; r < 80; r++) begin
         if ($urandom_range(0, 99) < 12) begin
            clear = 1'b1;
            tick();
            clear = 1'b0;
            m_idx = 0;
            check("rnd_clr_idx", opIndex, 0);
            check("rnd_clr_ops", operands, mvec());
         end else begin
            repeat ($urandom_range(0, 2)) tick();
            model_hs($urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                     $urandom_range(1, 6));
         end
      end
      tick();
      check("total_pulses", pulses, m_starts);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
